// File: rtl/reg_lane_assembler.sv
// Assembles a wide word from independently written lanes and hands it off over valid/ready.
// A rewrite of an already-written lane raises a one-cycle OUT_rewrite pulse.
module reg_lane_assembler #(
   parameter int LANES      = 4,
   parameter int LANE_W     = 4,
   parameter int FIRST_WINS = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [LANES-1:0]          IN_wr_en,
   input  logic [LANES*LANE_W-1:0]   IN_wr_dat,
   input  logic                      IN_flush,
   input  logic                      IN_ready,
   output logic                      OUT_wr_ready,
   output logic                      OUT_valid,
   output logic [LANES*LANE_W-1:0]   OUT_dat,
   output logic [LANES-1:0]          OUT_lane_vld,
   output logic                      OUT_rewrite
);

   logic [LANES*LANE_W-1:0] dat_q, dat_d;
   logic [LANES-1:0]        vld_q, vld_d;
   logic                    rewrite_q, rewrite_d;

   logic                    valid;
   logic                    wr_ready;
   logic                    handshake;
   logic [LANES-1:0]        accept;
   logic [LANES-1:0]        vld_base;

   always_comb begin
      valid     = &vld_q;
      wr_ready  = !IN_flush && (!valid || IN_ready);
      handshake = valid && IN_ready && !IN_flush;
      accept    = IN_wr_en & {LANES{wr_ready}};
      // A completing handshake frees every lane before this cycle's writes land.
      vld_base  = handshake ? '0 : vld_q;
   end

   always_comb begin
      dat_d     = dat_q;
      vld_d     = vld_base | accept;
      rewrite_d = |(accept & vld_base);
      for (int i = 0; i < LANES; i++) begin
         if (accept[i] && (!vld_base[i] || (FIRST_WINS == 0))) begin
            dat_d[i*LANE_W +: LANE_W] = IN_wr_dat[i*LANE_W +: LANE_W];
         end
      end
      // Flush drops the mask only; accept is already zero because wr_ready is low.
      if (IN_flush) begin
         vld_d     = '0;
         rewrite_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dat_q     <= '0;
         vld_q     <= '0;
         rewrite_q <= 1'b0;
      end else begin
         dat_q     <= dat_d;
         vld_q     <= vld_d;
         rewrite_q <= rewrite_d;
      end
   end

   assign OUT_wr_ready = wr_ready;
   assign OUT_valid    = valid;
   assign OUT_dat      = dat_q;
   assign OUT_lane_vld = vld_q;
   assign OUT_rewrite  = rewrite_q;

endmodule

// File: tb/tb_reg_lane_assembler.sv
// Directed bench for reg_lane_assembler: completed words go through a scoreboard queue,
// lane masks, handshake gating and rewrite pulses are checked directly.
module tb_reg_lane_assembler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  wr_en;
   logic [15:0] wr_dat;
   logic        flush;
   logic        ready;

   logic        wr_ready, valid, rewrite;
   logic [15:0] dat;
   logic [3:0]  lane_vld;
   logic        fw_wr_ready, fw_valid, fw_rewrite;
   logic [15:0] fw_dat;
   logic [3:0]  fw_lane_vld;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   reg_lane_assembler #(.LANES(4), .LANE_W(4), .FIRST_WINS(0)) u_dut (
      .clk(clk), .rst(rst), .IN_wr_en(wr_en), .IN_wr_dat(wr_dat),
      .IN_flush(flush), .IN_ready(ready), .OUT_wr_ready(wr_ready),
      .OUT_valid(valid), .OUT_dat(dat), .OUT_lane_vld(lane_vld),
      .OUT_rewrite(rewrite)
   );

   reg_lane_assembler #(.LANES(4), .LANE_W(4), .FIRST_WINS(1)) u_dut_fw (
      .clk(clk), .rst(rst), .IN_wr_en(wr_en), .IN_wr_dat(wr_dat),
      .IN_flush(flush), .IN_ready(ready), .OUT_wr_ready(fw_wr_ready),
      .OUT_valid(fw_valid), .OUT_dat(fw_dat), .OUT_lane_vld(fw_lane_vld),
      .OUT_rewrite(fw_rewrite)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] en, input logic [15:0] d,
                        input logic fl, input logic rdy);
      wr_en  = en;
      wr_dat = d;
      flush  = fl;
      ready  = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle a word is presented it must match the queue head;
   // the head retires when the word is consumed, flushed or reset away.
   initial begin
      forever begin
         @(negedge clk);
         if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("mon_unexpected_valid", {16'h0, dat}, 32'hDEAD_0000);
            end else begin
               chk("mon_word", {16'h0, dat}, {16'h0, exp_q[0]});
               if (ready || flush || rst) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      drive(4'h0, 16'h0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_valid",    {31'h0, valid},    32'h0);
      chk("rst_wr_ready", {31'h0, wr_ready}, 32'h1);
      chk("rst_lane_vld", {28'h0, lane_vld}, 32'h0);
      chk("rst_dat",      {16'h0, dat},      32'h0);
      chk("rst_rewrite",  {31'h0, rewrite},  32'h0);

      // One lane per cycle, ready held high
      drive(4'h1, 16'h0001, 1'b0, 1'b1); tick();
      drive(4'h2, 16'h0020, 1'b0, 1'b1); tick();
      drive(4'h4, 16'h0300, 1'b0, 1'b1); tick();
      exp_q.push_back(16'h4321);
      drive(4'h8, 16'h4000, 1'b0, 1'b1); tick();
      chk("seq_valid", {31'h0, valid}, 32'h1);
      chk("seq_dat",   {16'h0, dat},   32'h4321);
      drive(4'h0, 16'h0, 1'b0, 1'b1); tick();
      chk("seq_valid_one_cycle", {31'h0, valid}, 32'h0);

      // Full word held under backpressure, writes refused
      exp_q.push_back(16'h4321);
      drive(4'hF, 16'h4321, 1'b0, 1'b0); tick();
      drive(4'hF, 16'hFFFF, 1'b0, 1'b0);
      #1;
      chk("hold_wr_ready", {31'h0, wr_ready}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_dat",      {16'h0, dat},      32'h4321);
         chk("hold_lane_vld", {28'h0, lane_vld}, 32'hF);
         chk("hold_rewrite",  {31'h0, rewrite},  32'h0);
      end

      // Handshake with a same-cycle write to lane 2
      drive(4'h4, 16'h0A00, 1'b0, 1'b1);
      #1;
      chk("hs_wr_ready", {31'h0, wr_ready}, 32'h1);
      tick();
      chk("hs_valid",    {31'h0, valid},    32'h0);
      chk("hs_lane_vld", {28'h0, lane_vld}, 32'h4);
      chk("hs_dat",      {16'h0, dat},      32'h4A21);

      // Rewrite of lane 1 in both modes
      drive(4'h0, 16'h0, 1'b1, 1'b0); tick();
      chk("pre_rw_lane_vld", {28'h0, lane_vld}, 32'h0);
      drive(4'h2, 16'h0050, 1'b0, 1'b0); tick();
      chk("rw_first_no_pulse", {31'h0, rewrite}, 32'h0);
      drive(4'h2, 16'h0060, 1'b0, 1'b0); tick();
      chk("rw_pulse",       {31'h0, rewrite},    32'h1);
      chk("rw_pulse_fw",    {31'h0, fw_rewrite}, 32'h1);
      chk("rw_lane1",       {28'h0, dat[7:4]},   32'h6);
      chk("rw_lane1_fw",    {28'h0, fw_dat[7:4]}, 32'h5);
      drive(4'h0, 16'h0, 1'b0, 1'b0); tick();
      chk("rw_pulse_end",    {31'h0, rewrite},    32'h0);
      chk("rw_pulse_end_fw", {31'h0, fw_rewrite}, 32'h0);

      // Flush of a partial word with all writes requested
      drive(4'h1, 16'h0007, 1'b0, 1'b0); tick();
      chk("fl_pre_lane_vld", {28'h0, lane_vld}, 32'h3);
      drive(4'hF, 16'hFFFF, 1'b1, 1'b0);
      #1;
      chk("fl_wr_ready", {31'h0, wr_ready}, 32'h0);
      tick();
      chk("fl_lane_vld", {28'h0, lane_vld}, 32'h0);
      chk("fl_dat",      {16'h0, dat},      32'h4A67);
      chk("fl_valid",    {31'h0, valid},    32'h0);
      chk("fl_rewrite",  {31'h0, rewrite},  32'h0);

      // Reset while a word is being handed off
      exp_q.push_back(16'h1234);
      drive(4'hF, 16'h1234, 1'b0, 1'b1); tick();
      chk("rstw_valid_pre", {31'h0, valid}, 32'h1);
      rst = 1'b1;
      drive(4'h0, 16'h0, 1'b0, 1'b1); tick();
      rst = 1'b0;
      chk("rstw_dat",      {16'h0, dat},      32'h0);
      chk("rstw_lane_vld", {28'h0, lane_vld}, 32'h0);
      chk("rstw_valid",    {31'h0, valid},    32'h0);
      chk("rstw_dat_fw",   {16'h0, fw_dat},   32'h0);

      // Back-to-back full words, one per cycle
      exp_q.push_back(16'h1111);
      drive(4'hF, 16'h1111, 1'b0, 1'b1); tick();
      exp_q.push_back(16'h2222);
      drive(4'hF, 16'h2222, 1'b0, 1'b1); tick();
      chk("b2b_no_rewrite", {31'h0, rewrite}, 32'h0);
      chk("b2b_dat2",       {16'h0, dat},     32'h2222);
      exp_q.push_back(16'h3333);
      drive(4'hF, 16'h3333, 1'b0, 1'b1); tick();
      chk("b2b_dat3",  {16'h0, dat},   32'h3333);
      chk("b2b_valid", {31'h0, valid}, 32'h1);
      drive(4'h0, 16'h0, 1'b0, 1'b1); tick();
      tick();
      chk("b2b_valid_end", {31'h0, valid}, 32'h0);
      chk("sb_drained", exp_q.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
